cordic_rotate: RTL and testbench
================================

# cordic_rotate

Iterative CORDIC engine in rotation mode: rotates a signed 2-D vector (x_in, y_in) by an angle theta and returns the rotated vector. It is the inverse companion of the arctan (vectoring-mode) block. Fed with (0x2000, 0) it yields (cos θ, sin θ) for the motion-control pipeline. Operands are accepted one at a time through a start/busy/done handshake.

## Interface
- ITER, 14: number of micro-rotations (valid 8..15).
- GUARD, 2: extra integer bits on the internal x/y datapath (internal width 16+GUARD).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only when busy=0.
- x_in  in  16  signed Q2.13 (1.0 = 0x2000).
- y_in  in  16  signed Q2.13.
- theta  in  16  signed Q2.13 radians; valid range −π..+π (0x9B78..0x6488).
- busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse when x_out/y_out become valid.
- x_out  out  16  signed Q2.13 rotated x, saturated.
- y_out  out  16  signed Q2.13 rotated y, saturated.

## Operation
- FSM states: IDLE → PRE → ITER → [COMP] → DONE → IDLE.
- IDLE: on start=1, latch x_in, y_in and theta (sign-extended to 16+GUARD bits for x/y), then go to PRE. start while busy=1 is ignored; the input latches do not change.
- PRE (quadrant fold):
  - theta > 0x3244 (π/2): (x,y) ← (−y, x), z ← theta − 0x3244.
  - theta < −0x3244: (x,y) ← (y, −x), z ← theta + 0x3244.
  - Otherwise z ← theta, vector unchanged.
  - Iteration counter i ← 0.
- ITER, one micro-rotation per cycle for i = 0..ITER−1:
  - d = +1 if z ≥ 0, else −1.
  - x ← x − d·(y>>>i); y ← y + d·(x>>>i); z ← z − d·atan_i. Shifts are arithmetic and use the pre-update x/y.
  - atan_i ROM in Q2.13: 0x1922, 0x0ED6, 0x07D7, 0x03FB, 0x01FF, 0x0100, 0x0080, 0x0040, 0x0020, 0x0010, 0x0008, 0x0004, 0x0002, 0x0001, 0x0001.
  - Leave ITER when i = ITER−1.
- COMP (only when the macro is defined): x ← (x·0x136F)>>>13 and y likewise (K = 0.60725), full-precision product.
- DONE: saturate x and y to 16-bit signed (0x7FFF / 0x8000), register them into x_out/y_out, and assert done.
- theta outside ±0x6488: output value unspecified; the handshake still completes normally.
- Reset values: busy=0, done=0, x_out=0x0000, y_out=0x0000, state IDLE.

## Timing
- Start accepted at clock edge N. done=1 in the cycle following edge N+ITER+3 with COMP, or edge N+ITER+2 without.
- Default latency: 17 cycles with COMP, 16 without.
- busy rises the cycle after edge N.
- x_out/y_out update only on the done edge and hold until the next completion.
- done and busy fall together. A start in the same cycle as done is ignored; the earliest accepted start is the next cycle.
- rst mid-operation: everything returns to reset values on that edge, no done is emitted, and the result is discarded.
- rst and start in the same cycle: rst wins.

## Configuration
- CORDIC_GAIN_COMP_EN defined: the COMP state runs and outputs are gain-corrected (|out| ≈ |in|). Latency is ITER+3.
- Undefined: no multiplier and no COMP state. Outputs carry the CORDIC gain ≈1.6468 and latency is ITER+2.

## Test plan
- EN, x=0x2000, y=0, θ=0 → done at +17; x_out=0x2000±4, y_out=0x0000±4; busy high for 17 cycles.
- EN, x=0x2000, y=0, θ=0x1922 (π/4) → x_out=y_out=0x16A1±4. With θ=0x3244 → x_out≈0±4, y_out=0x2000±4.
- EN, x=0x2000, y=0, θ=0x9B78 (−π) → x_out=0xE000±4, y_out≈0±4. This exercises the negative fold.
- EN, x=y=0x7FFF, θ=0x1922 → y_out=0x7FFF (saturated), x_out≈0±4.
- Macro undefined, x=0x2000, y=0, θ=0 → x_out=0x34B3±4, done at +16.
- Pulse start again at +5 with different operands → ignored, first result unchanged. Assert rst at +8 → busy=0, outputs 0x0000, no done; a subsequent start completes normally.

Source files
------------

// File: rtl/cordic_rotate_if.sv
// Start/busy/done operand and result bundle for the rotation-mode CORDIC engine.
interface cordic_rotate_if;
  logic               start;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic signed [15:0] theta;
  logic               busy;
  logic               done;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;

  modport master (
    output start, x_in, y_in, theta,
    input  busy, done, x_out, y_out
  );

  modport slave (
    input  start, x_in, y_in, theta,
    output busy, done, x_out, y_out
  );
endinterface

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC, one micro-rotation per cycle; latency ITER+2 (ITER+3 with gain comp).
// CORDIC_GAIN_COMP_EN adds a COMP state scaling the result by K=0.60725; start is ignored while busy.
module cordic_rotate #(
  parameter int ITER  = 14,
  parameter int GUARD = 2
) (
  input  logic           clk,
  input  logic           rst,
  cordic_rotate_if.slave bus
);
  localparam int W = 16 + GUARD;
  localparam logic signed [W-1:0] MAXV     = W'(32'sd32767);
  localparam logic signed [W-1:0] MINV     = W'(-32'sd32768);
  localparam logic signed [16:0]  HALF_PI  = 17'sh03244;
  localparam logic signed [16:0]  NHALF_PI = -17'sh03244;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_COMP, S_DONE} state_t;

  state_t             state, state_nxt;
  logic signed [W-1:0] x_r, y_r;
  logic signed [16:0]  z_r;
  logic [3:0]          i_r;
  logic                busy_r, done_r;
  logic signed [15:0]  x_out_r, y_out_r;
  logic                accept;

  function automatic logic signed [16:0] atan_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_rom = 17'sh01922;
      4'd1:    atan_rom = 17'sh00ED6;
      4'd2:    atan_rom = 17'sh007D7;
      4'd3:    atan_rom = 17'sh003FB;
      4'd4:    atan_rom = 17'sh001FF;
      4'd5:    atan_rom = 17'sh00100;
      4'd6:    atan_rom = 17'sh00080;
      4'd7:    atan_rom = 17'sh00040;
      4'd8:    atan_rom = 17'sh00020;
      4'd9:    atan_rom = 17'sh00010;
      4'd10:   atan_rom = 17'sh00008;
      4'd11:   atan_rom = 17'sh00004;
      4'd12:   atan_rom = 17'sh00002;
      default: atan_rom = 17'sh00001;
    endcase
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [W-1:0] v);
    if (v > MAXV)      sat16 = 16'sh7FFF;
    else if (v < MINV) sat16 = 16'sh8000;
    else               sat16 = v[15:0];
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [14:0] K_GAIN = 15'sh136F;
  logic signed [W+14:0] prod_x, prod_y;
  assign prod_x = x_r * K_GAIN;
  assign prod_y = y_r * K_GAIN;
`endif

  // busy stays high through the done cycle, so a start coinciding with done is dropped
  assign accept = bus.start && !busy_r;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_PRE;
      S_PRE:  state_nxt = S_ITER;
      S_ITER: begin
        if (i_r == 4'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt = S_COMP;
`else
          state_nxt = S_DONE;
`endif
        end
      end
      S_COMP: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      x_out_r <= '0;
      y_out_r <= '0;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      i_r     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          busy_r <= accept;
          if (accept) begin
            x_r <= W'(bus.x_in);
            y_r <= W'(bus.y_in);
            z_r <= 17'(bus.theta);
          end
        end
        S_PRE: begin
          // fold into +-pi/2 so the iterations' convergence range covers it
          i_r <= '0;
          if (z_r > HALF_PI) begin
            x_r <= -y_r;
            y_r <= x_r;
            z_r <= z_r - HALF_PI;
          end else if (z_r < NHALF_PI) begin
            x_r <= y_r;
            y_r <= -x_r;
            z_r <= z_r + HALF_PI;
          end
        end
        S_ITER: begin
          i_r <= i_r + 4'd1;
          if (!z_r[16]) begin
            x_r <= x_r - (y_r >>> i_r);
            y_r <= y_r + (x_r >>> i_r);
            z_r <= z_r - atan_rom(i_r);
          end else begin
            x_r <= x_r + (y_r >>> i_r);
            y_r <= y_r - (x_r >>> i_r);
            z_r <= z_r + atan_rom(i_r);
          end
        end
        S_COMP: begin
`ifdef CORDIC_GAIN_COMP_EN
          x_r <= prod_x[W+12:13];
          y_r <= prod_y[W+12:13];
`endif
        end
        S_DONE: begin
          x_out_r <= sat16(x_r);
          y_out_r <= sat16(y_r);
          done_r  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.x_out = x_out_r;
  assign bus.y_out = y_out_r;
endmodule

// File: tb/tb_cordic_rotate.sv
// Directed scoreboard bench for cordic_rotate; expected vectors depend on CORDIC_GAIN_COMP_EN.
module tb_cordic_rotate;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 17;
  localparam int G   = 0;   // selects gain-corrected expectation column
`else
  localparam int LAT = 16;
  localparam int G   = 1;
`endif

  typedef struct {
    int x;
    int y;
    int tx;
    int ty;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   after_done = 1'b0;
  exp_t sb[$];

  cordic_rotate_if bus();

  cordic_rotate #(.ITER(14), .GUARD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  task automatic issue(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] th,
                       input bit push, input int ex, input int ey, input int tx, input int ty);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = xi;
    bus.y_in  = yi;
    bus.theta = th;
    if (push) begin
      e.x = ex; e.y = ey; e.tx = tx; e.ty = ty;
      e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Monitor: pops one expectation per done pulse, then checks the handshake closes next cycle
  always @(negedge clk) begin
    exp_t e;
    if (after_done) begin
      after_done = 1'b0;
      check("busy_after_done", int'(bus.busy), 0, 0);
      check("done_one_cycle", int'(bus.done), 0, 0);
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0, 0);
      end else begin
        e = sb.pop_front();
        check("x_out", int'(bus.x_out), e.x, e.tx);
        check("y_out", int'(bus.y_out), e.y, e.ty);
        check("done_cycle", cyc, e.cyc, 0);
        check("busy_at_done", int'(bus.busy), 1, 0);
      end
      after_done = 1'b1;
    end
  end

  // rows: x_in, y_in, theta, then {x, y, tol_x, tol_y} for gain-comp and raw builds
  logic [15:0] vin [5][3] = '{
    '{16'h2000, 16'h0000, 16'h0000},
    '{16'h2000, 16'h0000, 16'h1922},
    '{16'h2000, 16'h0000, 16'h3244},
    '{16'h2000, 16'h0000, 16'h9B78},
    '{16'h7FFF, 16'h7FFF, 16'h1922}
  };
  int vexp [5][2][4] = '{
    '{'{ 8192,     0, 4, 4}, '{ 13491,     0, 4, 4}},
    '{'{ 5793,  5793, 4, 4}, '{  9540,  9540, 7, 7}},
    '{'{    0,  8192, 4, 4}, '{     0, 13491, 7, 7}},
    '{'{-8192,     0, 4, 4}, '{-13491,     0, 7, 7}},
    '{'{    0, 32767, 4, 0}, '{     0, 32767, 7, 0}}
  };

  initial begin
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    bus.theta = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(bus.busy), 0, 0);
    check("reset_done", int'(bus.done), 0, 0);
    check("reset_x_out", int'(bus.x_out), 0, 0);
    check("reset_y_out", int'(bus.y_out), 0, 0);

    for (int v = 0; v < 5; v++) begin
      issue(vin[v][0], vin[v][1], vin[v][2], 1'b1,
            vexp[v][G][0], vexp[v][G][1], vexp[v][G][2], vexp[v][G][3]);
      repeat (LAT + 2) @(negedge clk);
    end

    // second start mid-operation must not disturb the first result
    issue(16'h2000, 16'h0000, 16'h0000, 1'b1,
          vexp[0][G][0], vexp[0][G][1], vexp[0][G][2], vexp[0][G][3]);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = 16'h1000;
    bus.y_in  = 16'h1000;
    bus.theta = 16'h1922;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    // reset mid-operation: no done, outputs cleared
    issue(16'h2000, 16'h0000, 16'h1922, 1'b0, 0, 0, 0, 0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0, 0);
    check("abort_done", int'(bus.done), 0, 0);
    check("abort_x_out", int'(bus.x_out), 0, 0);
    check("abort_y_out", int'(bus.y_out), 0, 0);
    repeat (LAT + 4) @(negedge clk);

    // reset and start together: reset wins
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_beats_start", int'(bus.busy), 0, 0);
    @(negedge clk);

    issue(vin[1][0], vin[1][1], vin[1][2], 1'b1,
          vexp[1][G][0], vexp[1][G][1], vexp[1][G][2], vexp[1][G][3]);
    repeat (LAT + 4) @(negedge clk);

    check("pending_results", sb.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
